mnist_batch_sequencer: RTL and testbench
========================================

Name: mnist_batch_sequencer

Overview:
On-chip batch self-test controller that replaces bench-driven single-image runs. It steps through NUM_IMGS embedded images and drives start/img_sel into mnist_top_synth. For each image it waits for done, checks the predicted digit against a parameter label table, and measures per-image and total inference cycles. It sits beside mnist_top_synth in the FPGA top; its results feed the board console/LEDs.

Parameters:
NUM_IMGS, 3, images per batch (1..2**SEL_W)
SEL_W, 2, img_sel width
DIGIT_W, 4, digit width
CYC_W, 32, cycle counter width
TIMEOUT_CYC, 250000, max WAIT cycles per image (10 ms at 25 MHz)
LABELS, {4'd3,4'd2,4'd6}, packed expected digits; image i at bits [i*DIGIT_W +: DIGIT_W]

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
run  in  1  pulse; starts a batch when idle
acc_start  out  1  one-cycle start pulse to accelerator
acc_sel  out  SEL_W  image select to accelerator
acc_valid  in  1  accelerator reports acc_sel is a valid image
acc_done  in  1  accelerator done (level, held until next start)
acc_digit  in  DIGIT_W  accelerator prediction
busy  out  1  batch in progress
batch_done  out  1  level; set at batch end, cleared by next accepted run
res_valid  out  1  one-cycle pulse per image result
res_idx  out  SEL_W  image index of result
res_digit  out  DIGIT_W  predicted digit (0 for skipped images)
res_pass  out  1  prediction matched label
pass_cnt, fail_cnt, skip_cnt  out  SEL_W+1 each  batch tallies
last_cycles  out  CYC_W  WAIT cycles of most recent image
total_cycles  out  CYC_W  sum of WAIT cycles over the batch, saturating
timeout_flag  out  1  sticky until next accepted run

Behaviour:
- Reset (rst_n=0 at a clk edge): every output is 0, FSM goes to IDLE. Reset mid-batch aborts immediately and acc_start is low in the following cycle.
- FSM states: IDLE, SETUP, CHECK, LAUNCH, WAIT, RECORD, DONE.
- IDLE: run=1 → clear counters, flags, batch_done and idx; go to SETUP. run is ignored in every other state.
- SETUP: drive acc_sel=idx and hold one cycle so acc_valid can settle → CHECK. acc_sel stays stable from SETUP through RECORD.
- CHECK: if acc_valid=0, skip_cnt+1, res_pass=0 → RECORD; else → LAUNCH.
- LAUNCH: acc_start=1 for exactly one cycle; clear the cycle counter and the arm flag → WAIT.
- WAIT: counter +1 each cycle. acc_done is ignored until it has been sampled low at least once since LAUNCH (arm flag), so a stale done from the previous image is rejected. When armed and acc_done=1: latch digit, compare with LABELS[idx], bump pass_cnt or fail_cnt → RECORD.
- Timeout: counter reaches TIMEOUT_CYC without a qualified done → timeout_flag=1, fail_cnt+1, res_pass=0 → RECORD, then DONE. The batch aborts regardless of idx.
- RECORD: res_valid=1 for one cycle; last_cycles=counter (0 for skipped images); total_cycles += counter, saturating at all-ones. If idx==NUM_IMGS-1 or timeout → DONE, else idx+1 → SETUP.
- DONE: busy=0, batch_done=1 → IDLE the same cycle. A run in that cycle is ignored; a run from the next cycle is accepted.
- busy=1 in every state except IDLE and DONE.
- Digit compare is an unsigned DIGIT_W equality. An acc_digit value ≥10 is a fail.

Optional Feature:
MNIST_SEQ_STOP_ON_FAIL_EN
- Defined: the first mismatch (not a skip) goes RECORD→DONE. Remaining images are neither launched nor counted.
- Undefined: mismatches are counted and the batch continues. Only a timeout aborts.

Decomposition:
- mnist_seq_pkg: state enum, default DIGIT_W/SEL_W/CYC_W constants, default LABELS localparam.
- One sub-module, mnist_seq_timer: counter with clear, enable, TIMEOUT_CYC compare, saturating accumulator; outputs count, timeout and total.
- The FSM, tallies and result registers stay in the top.

Test Plan:
- Accelerator model with 100-cycle latency returning 6,2,3; run pulse → three res_valid pulses, idx 0,1,2 all pass; pass_cnt=3, last_cycles=100, total_cycles=300, batch_done=1.
- Model returns 6,7,3 → fail_cnt=1 on idx 1, pass_cnt=2. With MNIST_SEQ_STOP_ON_FAIL_EN: only two results, pass_cnt=1, fail_cnt=1.
- acc_valid=0 for idx 1 → skip_cnt=1, no acc_start issued for idx 1, res_digit=0, last_cycles=0.
- acc_done held high from the previous run, new result after 50 cycles → the stale done is rejected and last_cycles=50.
- Model never asserts done, TIMEOUT_CYC=20 → timeout_flag=1 after 20 WAIT cycles, fail_cnt=1, batch ends after idx 0.
- rst_n low for one cycle during WAIT of idx 1 → all outputs 0 and IDLE next cycle. A run while busy has no effect on idx or counts.

Source files
------------

// File: rtl/mnist_seq_pkg.sv
// Shared types and default configuration for the MNIST batch self-test sequencer.
package mnist_seq_pkg;

    localparam int unsigned NUM_IMGS_DEF    = 3;
    localparam int unsigned SEL_W_DEF       = 2;
    localparam int unsigned DIGIT_W_DEF     = 4;
    localparam int unsigned CYC_W_DEF       = 32;
    localparam int unsigned TIMEOUT_CYC_DEF = 250000;

    // Expected digit of image i sits at bits [i*DIGIT_W +: DIGIT_W].
    localparam logic [NUM_IMGS_DEF*DIGIT_W_DEF-1:0] LABELS_DEF = {4'd3, 4'd2, 4'd6};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_CHECK  = 3'd2,
        S_LAUNCH = 3'd3,
        S_WAIT   = 3'd4,
        S_RECORD = 3'd5,
        S_DONE   = 3'd6
    } seq_state_e;

endpackage

// File: rtl/mnist_batch_sequencer_if.sv
// Sequencer <-> accelerator handshake: start pulse, image select, valid, done, digit.
interface mnist_batch_sequencer_if #(
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned DIGIT_W = 4
);

    logic               acc_start;
    logic [SEL_W-1:0]   acc_sel;
    logic               acc_valid;
    logic               acc_done;
    logic [DIGIT_W-1:0] acc_digit;

    modport master (
        output acc_start,
        output acc_sel,
        input  acc_valid,
        input  acc_done,
        input  acc_digit
    );

    modport slave (
        input  acc_start,
        input  acc_sel,
        output acc_valid,
        output acc_done,
        output acc_digit
    );

endinterface

// File: rtl/mnist_seq_timer.sv
// Per-image WAIT cycle counter with timeout compare and a saturating batch accumulator.
module mnist_seq_timer
    import mnist_seq_pkg::*;
#(
    parameter int unsigned CYC_W       = CYC_W_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             tot_clr_i,
    input  logic             tot_add_i,
    output logic [CYC_W-1:0] count_o,
    output logic [CYC_W-1:0] total_o,
    output logic             timeout_c
);

    logic [CYC_W-1:0] count_q, count_d;
    logic [CYC_W-1:0] total_q, total_d;
    logic [CYC_W:0]   sum_c;

    always_comb begin
        count_d = count_q;
        total_d = total_q;
        sum_c   = {1'b0, total_q} + {1'b0, count_q};

        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CYC_W'(1);
        end

        // Carry out of the add means the batch total has overflowed; pin it at all-ones.
        if (tot_clr_i) begin
            total_d = '0;
        end else if (tot_add_i) begin
            total_d = sum_c[CYC_W] ? '1 : sum_c[CYC_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            total_q <= '0;
        end else begin
            count_q <= count_d;
            total_q <= total_d;
        end
    end

    // High during the last permitted WAIT cycle, i.e. the TIMEOUT_CYC-th one.
    assign timeout_c = (count_q == CYC_W'(TIMEOUT_CYC - 1));
    assign count_o   = count_q;
    assign total_o   = total_q;

endmodule

// File: rtl/mnist_batch_sequencer.sv
// Batch self-test controller: launches each embedded image, grades the digit, tallies cycles.
// Build option MNIST_SEQ_STOP_ON_FAIL_EN ends the batch at the first digit mismatch.
module mnist_batch_sequencer
    import mnist_seq_pkg::*;
#(
    parameter int unsigned NUM_IMGS    = NUM_IMGS_DEF,
    parameter int unsigned SEL_W       = SEL_W_DEF,
    parameter int unsigned DIGIT_W     = DIGIT_W_DEF,
    parameter int unsigned CYC_W       = CYC_W_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter logic [NUM_IMGS*DIGIT_W-1:0] LABELS = LABELS_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run_i,
    mnist_batch_sequencer_if.master acc,
    output logic                   busy_o,
    output logic                   batch_done_o,
    output logic                   res_valid_o,
    output logic [SEL_W-1:0]       res_idx_o,
    output logic [DIGIT_W-1:0]     res_digit_o,
    output logic                   res_pass_o,
    output logic [SEL_W:0]         pass_cnt_o,
    output logic [SEL_W:0]         fail_cnt_o,
    output logic [SEL_W:0]         skip_cnt_o,
    output logic [CYC_W-1:0]       last_cycles_o,
    output logic [CYC_W-1:0]       total_cycles_o,
    output logic                   timeout_flag_o
);

    localparam int unsigned CNT_W = SEL_W + 1;

    seq_state_e state_q, state_d;

    logic [SEL_W-1:0]   idx_q, idx_d;
    logic               arm_q, arm_d;
    logic               abort_q, abort_d;
    logic               acc_start_q, acc_start_d;
    logic               busy_q, busy_d;
    logic               batch_done_q, batch_done_d;
    logic               res_valid_q, res_valid_d;
    logic [SEL_W-1:0]   res_idx_q, res_idx_d;
    logic [DIGIT_W-1:0] res_digit_q, res_digit_d;
    logic               res_pass_q, res_pass_d;
    logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic [CNT_W-1:0]   skip_cnt_q, skip_cnt_d;
    logic [CYC_W-1:0]   last_cycles_q, last_cycles_d;
    logic               timeout_q, timeout_d;

    logic               tmr_clr, tmr_en, tot_clr, tot_add;
    logic [CYC_W-1:0]   tmr_count, tmr_total;
    logic               tmr_timeout_c;
    logic               match_c;

    logic [DIGIT_W-1:0] label_tbl [NUM_IMGS];

    for (genvar g = 0; g < int'(NUM_IMGS); g++) begin : g_label
        assign label_tbl[g] = LABELS[g*DIGIT_W +: DIGIT_W];
    end

    // Labels are all below ten, so an out-of-range prediction can never compare equal.
    assign match_c = (acc.acc_digit == label_tbl[idx_q]);

    mnist_seq_timer #(
        .CYC_W       (CYC_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .tot_clr_i (tot_clr),
        .tot_add_i (tot_add),
        .count_o   (tmr_count),
        .total_o   (tmr_total),
        .timeout_c (tmr_timeout_c)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        arm_d         = arm_q;
        abort_d       = abort_q;
        batch_done_d  = batch_done_q;
        res_idx_d     = res_idx_q;
        res_digit_d   = res_digit_q;
        res_pass_d    = res_pass_q;
        pass_cnt_d    = pass_cnt_q;
        fail_cnt_d    = fail_cnt_q;
        skip_cnt_d    = skip_cnt_q;
        last_cycles_d = last_cycles_q;
        timeout_d     = timeout_q;
        tmr_clr       = 1'b0;
        tmr_en        = 1'b0;
        tot_clr       = 1'b0;
        tot_add       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run_i) begin
                    idx_d        = '0;
                    pass_cnt_d   = '0;
                    fail_cnt_d   = '0;
                    skip_cnt_d   = '0;
                    timeout_d    = 1'b0;
                    batch_done_d = 1'b0;
                    tot_clr      = 1'b1;
                    state_d      = S_SETUP;
                end
            end
            // Zeroing the counter here leaves a skipped image with a cycle count of 0.
            S_SETUP: begin
                tmr_clr = 1'b1;
                arm_d   = 1'b0;
                abort_d = 1'b0;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (!acc.acc_valid) begin
                    skip_cnt_d  = skip_cnt_q + CNT_W'(1);
                    res_idx_d   = idx_q;
                    res_digit_d = '0;
                    res_pass_d  = 1'b0;
                    state_d     = S_RECORD;
                end else begin
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                tmr_clr = 1'b1;
                arm_d   = 1'b0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                tmr_en = 1'b1;
                if (!acc.acc_done) begin
                    arm_d = 1'b1;
                end
                // A done only counts once it has been seen low since launch.
                if (arm_q && acc.acc_done) begin
                    res_idx_d   = idx_q;
                    res_digit_d = acc.acc_digit;
                    res_pass_d  = match_c;
                    if (match_c) begin
                        pass_cnt_d = pass_cnt_q + CNT_W'(1);
                    end else begin
                        fail_cnt_d = fail_cnt_q + CNT_W'(1);
`ifdef MNIST_SEQ_STOP_ON_FAIL_EN
                        abort_d = 1'b1;
`else
                        abort_d = abort_q;
`endif
                    end
                    state_d = S_RECORD;
                end else if (tmr_timeout_c) begin
                    timeout_d   = 1'b1;
                    fail_cnt_d  = fail_cnt_q + CNT_W'(1);
                    res_idx_d   = idx_q;
                    res_digit_d = '0;
                    res_pass_d  = 1'b0;
                    abort_d     = 1'b1;
                    state_d     = S_RECORD;
                end
            end
            S_RECORD: begin
                tot_add       = 1'b1;
                last_cycles_d = tmr_count;
                if (abort_q || (idx_q == SEL_W'(NUM_IMGS - 1))) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + SEL_W'(1);
                    state_d = S_SETUP;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_DONE) begin
            batch_done_d = 1'b1;
        end
        acc_start_d = (state_d == S_LAUNCH);
        res_valid_d = (state_d == S_RECORD);
        busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            arm_q         <= 1'b0;
            abort_q       <= 1'b0;
            acc_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            batch_done_q  <= 1'b0;
            res_valid_q   <= 1'b0;
            res_idx_q     <= '0;
            res_digit_q   <= '0;
            res_pass_q    <= 1'b0;
            pass_cnt_q    <= '0;
            fail_cnt_q    <= '0;
            skip_cnt_q    <= '0;
            last_cycles_q <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            arm_q         <= arm_d;
            abort_q       <= abort_d;
            acc_start_q   <= acc_start_d;
            busy_q        <= busy_d;
            batch_done_q  <= batch_done_d;
            res_valid_q   <= res_valid_d;
            res_idx_q     <= res_idx_d;
            res_digit_q   <= res_digit_d;
            res_pass_q    <= res_pass_d;
            pass_cnt_q    <= pass_cnt_d;
            fail_cnt_q    <= fail_cnt_d;
            skip_cnt_q    <= skip_cnt_d;
            last_cycles_q <= last_cycles_d;
            timeout_q     <= timeout_d;
        end
    end

    assign acc.acc_start  = acc_start_q;
    assign acc.acc_sel    = idx_q;
    assign busy_o         = busy_q;
    assign batch_done_o   = batch_done_q;
    assign res_valid_o    = res_valid_q;
    assign res_idx_o      = res_idx_q;
    assign res_digit_o    = res_digit_q;
    assign res_pass_o     = res_pass_q;
    assign pass_cnt_o     = pass_cnt_q;
    assign fail_cnt_o     = fail_cnt_q;
    assign skip_cnt_o     = skip_cnt_q;
    assign last_cycles_o  = last_cycles_q;
    assign total_cycles_o = tmr_total;
    assign timeout_flag_o = timeout_q;

endmodule

// File: tb/tb_mnist_batch_sequencer.sv
// Directed bench for mnist_batch_sequencer with a behavioural accelerator model.
module tb_mnist_batch_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0;
    logic run2 = 1'b0;

    always #5 clk = ~clk;

    int total_n = 0;
    int bad_n = 0;

    mnist_batch_sequencer_if #(.SEL_W(2), .DIGIT_W(4)) acc ();
    mnist_batch_sequencer_if #(.SEL_W(2), .DIGIT_W(4)) acc2 ();

    logic        busy, batch_done, res_valid, res_pass, timeout_flag;
    logic [1:0]  res_idx;
    logic [3:0]  res_digit;
    logic [2:0]  pass_cnt, fail_cnt, skip_cnt;
    logic [31:0] last_cycles, total_cycles;

    logic        busy2, batch_done2, res_valid2, res_pass2, timeout_flag2;
    logic [1:0]  res_idx2;
    logic [3:0]  res_digit2;
    logic [2:0]  pass_cnt2, fail_cnt2, skip_cnt2;
    logic [31:0] last_cycles2, total_cycles2;

    mnist_batch_sequencer dut (
        .clk(clk), .rst_n(rst_n), .run_i(run), .acc(acc),
        .busy_o(busy), .batch_done_o(batch_done), .res_valid_o(res_valid),
        .res_idx_o(res_idx), .res_digit_o(res_digit), .res_pass_o(res_pass),
        .pass_cnt_o(pass_cnt), .fail_cnt_o(fail_cnt), .skip_cnt_o(skip_cnt),
        .last_cycles_o(last_cycles), .total_cycles_o(total_cycles),
        .timeout_flag_o(timeout_flag)
    );

    mnist_batch_sequencer #(.TIMEOUT_CYC(20)) dut2 (
        .clk(clk), .rst_n(rst_n), .run_i(run2), .acc(acc2),
        .busy_o(busy2), .batch_done_o(batch_done2), .res_valid_o(res_valid2),
        .res_idx_o(res_idx2), .res_digit_o(res_digit2), .res_pass_o(res_pass2),
        .pass_cnt_o(pass_cnt2), .fail_cnt_o(fail_cnt2), .skip_cnt_o(skip_cnt2),
        .last_cycles_o(last_cycles2), .total_cycles_o(total_cycles2),
        .timeout_flag_o(timeout_flag2)
    );

    // Accelerator model: done is first visible in the m_lat-th cycle after the start pulse.
    int         m_lat = 100;
    bit         m_stale = 1'b0;
    logic [2:0] m_valid = 3'b111;
    logic [3:0] m_dig [3];
    logic       m_done;
    logic [3:0] m_digit;
    logic [1:0] m_sel;
    int         m_cnt = 0;
    int         start_tot [3];

    assign acc.acc_valid  = m_valid[acc.acc_sel];
    assign acc.acc_done   = m_done;
    assign acc.acc_digit  = m_digit;
    assign acc2.acc_valid = 1'b1;
    assign acc2.acc_done  = 1'b0;
    assign acc2.acc_digit = 4'd0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_cnt   <= 0;
            m_done  <= 1'b0;
            m_digit <= 4'd0;
            m_sel   <= 2'd0;
        end else if (acc.acc_start) begin
            m_cnt <= 1;
            m_sel <= acc.acc_sel;
            start_tot[acc.acc_sel] <= start_tot[acc.acc_sel] + 1;
            if (!m_stale) m_done <= 1'b0;
        end else if (m_cnt != 0) begin
            if (m_cnt == 5) m_done <= 1'b0;
            if (m_cnt == m_lat - 1) begin
                m_done  <= 1'b1;
                m_digit <= m_dig[m_sel];
                m_cnt   <= 0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // Result monitor; last_cycles is captured the cycle after each res_valid pulse.
    logic [1:0]  q_idx [$];
    logic [3:0]  q_dig [$];
    logic        q_pass [$];
    logic [31:0] q_lc [$];
    logic        prev_rv = 1'b0;
    int          n_rv2 = 0;

    always @(negedge clk) begin
        if (prev_rv) q_lc.push_back(last_cycles);
        prev_rv = res_valid;
        if (res_valid) begin
            q_idx.push_back(res_idx);
            q_dig.push_back(res_digit);
            q_pass.push_back(res_pass);
        end
        if (res_valid2) n_rv2++;
    end

    task automatic run_batch(output bit to);
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (batch_done) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total_n++;
        if ({busy, batch_done, res_valid, acc.acc_start} !== 4'b0) begin
            bad_n++; $display("FAIL reset_flags got=%b exp=0000", {busy, batch_done, res_valid, acc.acc_start});
        end
        total_n++;
        if ({pass_cnt, fail_cnt, skip_cnt, timeout_flag, acc.acc_sel} !== 12'b0) begin
            bad_n++; $display("FAIL reset_counts got=%h exp=0", {pass_cnt, fail_cnt, skip_cnt, timeout_flag, acc.acc_sel});
        end
        total_n++;
        if (total_cycles !== 32'd0 || last_cycles !== 32'd0) begin
            bad_n++; $display("FAIL reset_cycles got=%0d/%0d exp=0/0", total_cycles, last_cycles);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total_n++;
        if (busy !== 1'b0 || acc.acc_start !== 1'b0) begin
            bad_n++; $display("FAIL reset_idle got=%b%b exp=00", busy, acc.acc_start);
        end
    endtask

    task automatic test_all_pass();
        logic [3:0] exp_d [3] = '{4'd6, 4'd2, 4'd3};
        int n0, l0, s[3];
        bit to;
        m_dig = '{4'd6, 4'd2, 4'd3};
        m_valid = 3'b111; m_lat = 100; m_stale = 1'b0;
        n0 = q_idx.size(); l0 = q_lc.size();
        for (int i = 0; i < 3; i++) s[i] = start_tot[i];
        run_batch(to);
        total_n++;
        if (to) begin bad_n++; $display("FAIL pass_timeout got=no_batch_done exp=batch_done"); end
        total_n++;
        if (q_idx.size() - n0 !== 3) begin
            bad_n++; $display("FAIL pass_nres got=%0d exp=3", q_idx.size() - n0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                total_n++;
                if (q_idx[n0+i] !== 2'(i) || q_dig[n0+i] !== exp_d[i] || q_pass[n0+i] !== 1'b1) begin
                    bad_n++; $display("FAIL pass_res%0d got=idx%0d dig%0d pass%0d exp=idx%0d dig%0d pass1",
                                      i, q_idx[n0+i], q_dig[n0+i], q_pass[n0+i], i, exp_d[i]);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            total_n++;
            if (start_tot[i] - s[i] !== 1) begin
                bad_n++; $display("FAIL pass_starts%0d got=%0d exp=1", i, start_tot[i] - s[i]);
            end
            if (q_lc.size() - l0 == 3) begin
                total_n++;
                if (q_lc[l0+i] !== 32'd100) begin
                    bad_n++; $display("FAIL pass_lc%0d got=%0d exp=100", i, q_lc[l0+i]);
                end
            end
        end
        total_n++;
        if (pass_cnt !== 3'd3 || fail_cnt !== 3'd0 || skip_cnt !== 3'd0) begin
            bad_n++; $display("FAIL pass_cnts got=%0d/%0d/%0d exp=3/0/0", pass_cnt, fail_cnt, skip_cnt);
        end
        total_n++;
        if (last_cycles !== 32'd100 || total_cycles !== 32'd300) begin
            bad_n++; $display("FAIL pass_cycles got=%0d/%0d exp=100/300", last_cycles, total_cycles);
        end
        total_n++;
        if (batch_done !== 1'b1 || busy !== 1'b0 || timeout_flag !== 1'b0) begin
            bad_n++; $display("FAIL pass_flags got=%b%b%b exp=100", batch_done, busy, timeout_flag);
        end
    endtask

    task automatic test_mismatch();
        int n0, s2, exp_n, exp_pass, exp_tot, exp_s2;
        bit to;
`ifdef MNIST_SEQ_STOP_ON_FAIL_EN
        exp_n = 2; exp_pass = 1; exp_tot = 200; exp_s2 = 0;
`else
        exp_n = 3; exp_pass = 2; exp_tot = 300; exp_s2 = 1;
`endif
        m_dig = '{4'd6, 4'd7, 4'd3};
        n0 = q_idx.size(); s2 = start_tot[2];
        run_batch(to);
        total_n++;
        if (to) begin bad_n++; $display("FAIL mis_timeout got=no_batch_done exp=batch_done"); end
        total_n++;
        if (q_idx.size() - n0 !== exp_n) begin
            bad_n++; $display("FAIL mis_nres got=%0d exp=%0d", q_idx.size() - n0, exp_n);
        end
        total_n++;
        if (pass_cnt !== 3'(exp_pass) || fail_cnt !== 3'd1) begin
            bad_n++; $display("FAIL mis_cnts got=%0d/%0d exp=%0d/1", pass_cnt, fail_cnt, exp_pass);
        end
        if (q_idx.size() - n0 >= 2) begin
            total_n++;
            if (q_idx[n0+1] !== 2'd1 || q_dig[n0+1] !== 4'd7 || q_pass[n0+1] !== 1'b0) begin
                bad_n++; $display("FAIL mis_res1 got=idx%0d dig%0d pass%0d exp=idx1 dig7 pass0",
                                  q_idx[n0+1], q_dig[n0+1], q_pass[n0+1]);
            end
        end
        total_n++;
        if (total_cycles !== 32'(exp_tot) || start_tot[2] - s2 !== exp_s2) begin
            bad_n++; $display("FAIL mis_tot got=%0d/%0d exp=%0d/%0d", total_cycles, start_tot[2] - s2, exp_tot, exp_s2);
        end
    endtask

    task automatic test_skip();
        int n0, l0, s1;
        bit to;
        m_dig = '{4'd6, 4'd2, 4'd3};
        m_valid = 3'b101;
        n0 = q_idx.size(); l0 = q_lc.size(); s1 = start_tot[1];
        run_batch(to);
        m_valid = 3'b111;
        total_n++;
        if (to) begin bad_n++; $display("FAIL skip_timeout got=no_batch_done exp=batch_done"); end
        total_n++;
        if (skip_cnt !== 3'd1 || pass_cnt !== 3'd2 || fail_cnt !== 3'd0) begin
            bad_n++; $display("FAIL skip_cnts got=%0d/%0d/%0d exp=1/2/0", skip_cnt, pass_cnt, fail_cnt);
        end
        total_n++;
        if (start_tot[1] - s1 !== 0) begin
            bad_n++; $display("FAIL skip_start got=%0d exp=0", start_tot[1] - s1);
        end
        total_n++;
        if (q_idx.size() - n0 !== 3 || q_lc.size() - l0 !== 3) begin
            bad_n++; $display("FAIL skip_nres got=%0d exp=3", q_idx.size() - n0);
        end else if (q_idx[n0+1] !== 2'd1 || q_dig[n0+1] !== 4'd0 || q_pass[n0+1] !== 1'b0 || q_lc[l0+1] !== 32'd0) begin
            bad_n++; $display("FAIL skip_res1 got=idx%0d dig%0d pass%0d lc%0d exp=idx1 dig0 pass0 lc0",
                              q_idx[n0+1], q_dig[n0+1], q_pass[n0+1], q_lc[l0+1]);
        end
        total_n++;
        if (total_cycles !== 32'd200 || last_cycles !== 32'd100) begin
            bad_n++; $display("FAIL skip_cycles got=%0d/%0d exp=200/100", total_cycles, last_cycles);
        end
    endtask

    task automatic test_stale_done();
        int l0;
        bit to;
        m_stale = 1'b1; m_lat = 50;
        l0 = q_lc.size();
        run_batch(to);
        m_stale = 1'b0; m_lat = 100;
        total_n++;
        if (to) begin bad_n++; $display("FAIL stale_timeout got=no_batch_done exp=batch_done"); end
        total_n++;
        if (pass_cnt !== 3'd3 || fail_cnt !== 3'd0 || total_cycles !== 32'd150) begin
            bad_n++; $display("FAIL stale_cnts got=%0d/%0d/%0d exp=3/0/150", pass_cnt, fail_cnt, total_cycles);
        end
        total_n++;
        if (q_lc.size() - l0 !== 3) begin
            bad_n++; $display("FAIL stale_nres got=%0d exp=3", q_lc.size() - l0);
        end else if (q_lc[l0] !== 32'd50 || q_lc[l0+1] !== 32'd50 || q_lc[l0+2] !== 32'd50) begin
            bad_n++; $display("FAIL stale_lc got=%0d,%0d,%0d exp=50,50,50", q_lc[l0], q_lc[l0+1], q_lc[l0+2]);
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        bit to;
        n0 = q_idx.size();
        @(negedge clk); run = 1'b1;
        @(negedge clk); run = 1'b0;
        total_n++;
        if (busy !== 1'b1 || batch_done !== 1'b0) begin
            bad_n++; $display("FAIL b2b_accept got=busy%b done%b exp=busy1 done0", busy, batch_done);
        end
        repeat (150) @(negedge clk);
        run = 1'b1;
        @(negedge clk); run = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (batch_done) begin to = 1'b0; break; end
            @(negedge clk);
        end
        #1;
        total_n++;
        if (to) begin bad_n++; $display("FAIL b2b_timeout got=no_batch_done exp=batch_done"); end
        total_n++;
        if (q_idx.size() - n0 !== 3 || pass_cnt !== 3'd3 || total_cycles !== 32'd300) begin
            bad_n++; $display("FAIL b2b_busy_run got=%0d/%0d/%0d exp=3/3/300", q_idx.size() - n0, pass_cnt, total_cycles);
        end else if (q_idx[n0] !== 2'd0 || q_idx[n0+1] !== 2'd1 || q_idx[n0+2] !== 2'd2) begin
            bad_n++; $display("FAIL b2b_idx got=%0d,%0d,%0d exp=0,1,2", q_idx[n0], q_idx[n0+1], q_idx[n0+2]);
        end
        // run presented during the single DONE cycle must be dropped
        run = 1'b1;
        @(negedge clk); run = 1'b0;
        repeat (3) @(negedge clk);
        total_n++;
        if (busy !== 1'b0 || batch_done !== 1'b1) begin
            bad_n++; $display("FAIL b2b_done_run got=busy%b done%b exp=busy0 done1", busy, batch_done);
        end
    endtask

    task automatic test_timeout();
        int n2;
        bit to;
        n2 = n_rv2;
        @(negedge clk); run2 = 1'b1;
        @(negedge clk); run2 = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (batch_done2) begin to = 1'b0; break; end
            @(negedge clk);
        end
        #1;
        total_n++;
        if (to) begin bad_n++; $display("FAIL to_end got=no_batch_done exp=batch_done"); end
        total_n++;
        if (timeout_flag2 !== 1'b1 || fail_cnt2 !== 3'd1 || pass_cnt2 !== 3'd0) begin
            bad_n++; $display("FAIL to_flags got=%b/%0d/%0d exp=1/1/0", timeout_flag2, fail_cnt2, pass_cnt2);
        end
        total_n++;
        if (last_cycles2 !== 32'd20 || total_cycles2 !== 32'd20) begin
            bad_n++; $display("FAIL to_cycles got=%0d/%0d exp=20/20", last_cycles2, total_cycles2);
        end
        total_n++;
        if (n_rv2 - n2 !== 1 || res_idx2 !== 2'd0 || res_pass2 !== 1'b0) begin
            bad_n++; $display("FAIL to_res got=n%0d idx%0d pass%b exp=n1 idx0 pass0", n_rv2 - n2, res_idx2, res_pass2);
        end
    endtask

    task automatic test_reset_mid();
        int s1, n0;
        bit to;
        s1 = start_tot[1];
        @(negedge clk); run = 1'b1;
        @(negedge clk); run = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if (start_tot[1] != s1) begin to = 1'b0; break; end
            @(negedge clk);
        end
        total_n++;
        if (to) begin bad_n++; $display("FAIL rmid_launch got=no_start exp=start_idx1"); end
        repeat (10) @(negedge clk);
        total_n++;
        if (busy !== 1'b1 || pass_cnt !== 3'd1) begin
            bad_n++; $display("FAIL rmid_pre got=busy%b pass%0d exp=busy1 pass1", busy, pass_cnt);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total_n++;
        if ({busy, batch_done, res_valid, res_pass, acc.acc_start, timeout_flag2} !== 6'b0) begin
            bad_n++; $display("FAIL rmid_flags got=%b exp=000000", {busy, batch_done, res_valid, res_pass, acc.acc_start, timeout_flag2});
        end
        total_n++;
        if ({pass_cnt, fail_cnt, skip_cnt, res_idx, res_digit, acc.acc_sel} !== 17'b0) begin
            bad_n++; $display("FAIL rmid_regs got=%h exp=0", {pass_cnt, fail_cnt, skip_cnt, res_idx, res_digit, acc.acc_sel});
        end
        total_n++;
        if (last_cycles !== 32'd0 || total_cycles !== 32'd0) begin
            bad_n++; $display("FAIL rmid_cycles got=%0d/%0d exp=0/0", last_cycles, total_cycles);
        end
        n0 = q_idx.size();
        repeat (150) @(negedge clk);
        total_n++;
        if (q_idx.size() !== n0 || busy !== 1'b0) begin
            bad_n++; $display("FAIL rmid_idle got=nres%0d busy%b exp=nres0 busy0", q_idx.size() - n0, busy);
        end
    endtask

    initial begin
        m_dig = '{4'd6, 4'd2, 4'd3};
        test_reset();
        test_all_pass();
        test_mismatch();
        test_skip();
        test_stale_done();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
